// File: rtl/gcd_arbiter.sv
// gcd_arbiter
// Round-robin arbiter and sequencer that shares one GCD datapath between
// N_REQ requesters. It accepts one operand pair at a time, drives the GCD
// input handshake, captures the GCD result and returns it on a single
// tagged response channel. Exactly one job is in flight at any time.
//
// Ports:
//   clock, reset          single clock, synchronous active-high reset
//   req_valid/req_ready   per-requester handshake (req_ready is one-hot or zero)
//   req_x, req_y          packed operands, requester i at [i*WIDTH +: WIDTH]
//   gcd_input_*           input handshake and operands towards the GCD
//   gcd_output_*          result strobe and value from the GCD
//   resp_valid/ready      response handshake, resp_id tags the owner
//   resp_bits             GCD result
//   busy                  high whenever a job is in progress
//   done_count            completed responses, wraps at 16 bits
module gcd_arbiter #(
   parameter int N_REQ = 4,
   parameter int WIDTH = 32,
   parameter int ID_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic [N_REQ-1:0]       req_valid,
   output logic [N_REQ-1:0]       req_ready,
   input  logic [N_REQ*WIDTH-1:0] req_x,
   input  logic [N_REQ*WIDTH-1:0] req_y,
   output logic                   gcd_input_valid,
   input  logic                   gcd_input_ready,
   output logic [WIDTH-1:0]       gcd_input_bits_x,
   output logic [WIDTH-1:0]       gcd_input_bits_y,
   input  logic                   gcd_output_valid,
   input  logic [WIDTH-1:0]       gcd_output_bits,
   output logic                   resp_valid,
   input  logic                   resp_ready,
   output logic [ID_W-1:0]        resp_id,
   output logic [WIDTH-1:0]       resp_bits,
   output logic                   busy,
   output logic [15:0]            done_count
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_RESP  = 2'd3
   } state_t;

   state_t             state_r;
   state_t             state_n_s;
   logic [ID_W-1:0]    ptr_r;
   logic [ID_W-1:0]    id_r;
   logic [WIDTH-1:0]   x_r;
   logic [WIDTH-1:0]   y_r;
   logic [WIDTH-1:0]   res_r;
   logic [15:0]        done_count_r;
   logic               grant_found_s;
   logic [ID_W-1:0]    grant_id_s;
   logic [N_REQ-1:0]   req_ready_s;
   logic [ID_W-1:0]    ptr_next_s;

   // Rotating priority search: scan ptr, ptr+1, ... with wrap modulo N_REQ;
   // the first valid requester found wins.
   always_comb begin
      int   idx;
      logic hit;
      grant_found_s = 1'b0;
      grant_id_s    = '0;
      for (int k = 0; k < N_REQ; k++) begin
         idx           = (int'(ptr_r) + k >= N_REQ) ? (int'(ptr_r) + k - N_REQ) : (int'(ptr_r) + k);
         hit           = req_valid[idx] & ~grant_found_s;
         grant_id_s    = hit ? ID_W'(idx) : grant_id_s;
         grant_found_s = grant_found_s | hit;
      end
   end

   // Pointer moves one past the requester just served, wrapping for any N_REQ.
   always_comb begin
      ptr_next_s = (id_r == ID_W'(N_REQ - 1)) ? '0 : (id_r + ID_W'(1));
   end

   // Next-state logic and the combinational accept strobe.
   always_comb begin
      state_n_s   = state_r;
      req_ready_s = '0;
      case (state_r)
         ST_IDLE: begin
            if (grant_found_s) begin
               state_n_s   = ST_ISSUE;
               req_ready_s = {{(N_REQ-1){1'b0}}, 1'b1} << grant_id_s;
            end else begin
               state_n_s   = ST_IDLE;
            end
         end
         ST_ISSUE: begin
            if (gcd_input_ready) begin
               state_n_s = ST_WAIT;
            end else begin
               state_n_s = ST_ISSUE;
            end
         end
         ST_WAIT: begin
            if (gcd_output_valid) begin
               state_n_s = ST_RESP;
            end else begin
               state_n_s = ST_WAIT;
            end
         end
         ST_RESP: begin
            if (resp_ready) begin
               state_n_s = ST_IDLE;
            end else begin
               state_n_s = ST_RESP;
            end
         end
         default: begin
            state_n_s = ST_IDLE;
         end
      endcase
   end

   // State, operand/result latches, round-robin pointer and completion counter.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_r      <= ST_IDLE;
         ptr_r        <= '0;
         id_r         <= '0;
         x_r          <= '0;
         y_r          <= '0;
         res_r        <= '0;
         done_count_r <= 16'd0;
      end else begin
         state_r <= state_n_s;
         case (state_r)
            ST_IDLE: begin
               if (grant_found_s) begin
                  id_r <= grant_id_s;
                  x_r  <= req_x[int'(grant_id_s)*WIDTH +: WIDTH];
                  y_r  <= req_y[int'(grant_id_s)*WIDTH +: WIDTH];
               end
            end
            ST_WAIT: begin
               if (gcd_output_valid) begin
                  res_r <= gcd_output_bits;
               end
            end
            ST_RESP: begin
               if (resp_ready) begin
                  ptr_r        <= ptr_next_s;
                  done_count_r <= done_count_r + 16'd1;
               end
            end
            default: begin
            end
         endcase
      end
   end

   // Outputs are decodes of the state register or direct register taps,
   // except req_ready which must answer in the same IDLE cycle.
   assign req_ready        = req_ready_s;
   assign gcd_input_valid  = (state_r == ST_ISSUE);
   assign gcd_input_bits_x = x_r;
   assign gcd_input_bits_y = y_r;
   assign resp_valid       = (state_r == ST_RESP);
   assign resp_id          = id_r;
   assign resp_bits        = res_r;
   assign busy             = (state_r != ST_IDLE);
   assign done_count       = done_count_r;

endmodule

// File: doc/gcd_arbiter.md
# gcd_arbiter

Round-robin arbiter and sequencer that shares one `GCD` datapath between `N_REQ` independent requesters. Sits directly in front of the `GCD` instance: it accepts one operand pair at a time from the requesters, drives the GCD input handshake, captures the GCD result and returns it on a single tagged response channel. Exactly one job is in flight at any time.

## Interface
- `N_REQ`, 4: number of requesters, 2..8.
- `WIDTH`, 32: operand/result width; must match the `GCD` instance.
- `ID_W`, `$clog2(N_REQ)`: requester tag width, minimum 1.

Ports:
- `clock`  in  1  single clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-high; shared with the `GCD` instance.
- `req_valid`  in  N_REQ  per-requester operand pair valid.
- `req_ready`  out  N_REQ  per-requester accept; at most one bit set.
- `req_x`  in  N_REQ*WIDTH  packed x operands; requester i at bits [i*WIDTH +: WIDTH].
- `req_y`  in  N_REQ*WIDTH  packed y operands, same packing.
- `gcd_input_valid`  out  1  to GCD `input_valid`.
- `gcd_input_ready`  in  1  from GCD `input_ready`.
- `gcd_input_bits_x`, `gcd_input_bits_y`  out  WIDTH  to GCD operands.
- `gcd_output_valid`  in  1  from GCD `output_valid`.
- `gcd_output_bits`  in  WIDTH  from GCD `output_bits`.
- `resp_valid`  out  1  result available.
- `resp_ready`  in  1  response consumer accept.
- `resp_id`  out  ID_W  index of the requester that owns the result.
- `resp_bits`  out  WIDTH  GCD result.
- `busy`  out  1  high in any state other than IDLE.
- `done_count`  out  16  completed responses, wraps 0xFFFF -> 0.

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP. Reset state IDLE.
- IDLE: grant = first i with `req_valid[i]` searching `ptr, ptr+1, ... , N_REQ-1, 0, ...`. `req_ready[grant]` is driven combinationally high in the same cycle. The block latches x, y and id = grant, then moves to ISSUE. If no `req_valid` is set, it stays in IDLE with all `req_ready` low.
- `req_ready` is low in every other state. Requests stay pending while the block is not in IDLE.
- ISSUE: `gcd_input_valid`=1, and operands come from the latched registers. The cycle with `gcd_input_ready`=1 fires, and the block moves to WAIT. Otherwise it holds with operands stable.
- WAIT: `gcd_input_valid`=0. The first cycle with `gcd_output_valid`=1 latches `gcd_output_bits` into the result register, and the block moves to RESP. `gcd_output_valid` is ignored in IDLE, ISSUE and RESP.
- RESP: `resp_valid`=1 with `resp_id` and `resp_bits` held stable. When `resp_ready`=1, the block moves to IDLE, `ptr` <= (id+1) mod N_REQ, and `done_count` increments.
- Fairness: a continuously asserting requester waits for at most N_REQ-1 other jobs.
- Arithmetic: `ptr` wraps modulo N_REQ for non-power-of-two N_REQ. No operand transformation is applied; the block passes operands through unchanged.

## Timing
- Reset values: state IDLE, `ptr`=0, `req_ready`=0, `gcd_input_valid`=0, `resp_valid`=0, `resp_id`=0, `resp_bits`=0, `busy`=0, `done_count`=0. Operand and id registers are cleared to 0.
- Accept at cycle t (IDLE) -> `gcd_input_valid` high at t+1. GCD fire at cycle f >= t+1 -> WAIT from f+1. GCD `output_valid` at cycle k -> `resp_valid` at k+1.
- The block never has `gcd_input_valid` high while a GCD job is outstanding.
- RESP handshake at cycle r -> IDLE at r+1. The next grant is at the earliest r+1, so there is a one-cycle bubble by design and no RESP->ISSUE bypass.
- Back-to-back throughput is therefore at most one job per (GCD latency + 3) cycles.
- `reset` asserted in any state returns all outputs to their reset values on the next edge. The in-flight job is discarded with no response and is not counted. The GCD is reset by the same signal.
- If `resp_ready` is held low, the block stalls in RESP indefinitely, and no new requests are accepted.

## Test plan
- Single job: requester 2 sends x=48, y=18, with resp_ready tied high. Required: `req_ready[2]` pulses in the accept cycle, and later `resp_valid` with `resp_id`=2, `resp_bits`=6. `done_count`=1 afterwards.
- Round-robin: all 4 requesters are valid simultaneously and continuously with distinct pairs (12,8), (35,14), (81,27), (17,5). Required: responses in order id 0,1,2,3,0 with results 4,7,27,1,4.
- GCD stall: `gcd_input_ready` is held low for 5 cycles during ISSUE. Required: `gcd_input_valid` stays high with stable operands. Exactly one fire occurs, followed by a single response.
- Response backpressure: `resp_ready` is low for 10 cycles while a new request is pending. Required: `resp_valid`, `resp_id` and `resp_bits` stay stable, `req_ready` stays all-zero, and the next grant comes on the cycle after the handshake.
- Reset mid-job: `reset` is pulsed for 1 cycle while in WAIT. Required: all outputs are at reset values, no response is produced for the aborted job, `done_count`=0, and the next request completes normally from `ptr`=0.
- Counter wrap: drive 65537 jobs (or force `done_count`=0xFFFF). Required: `done_count` wraps to 0 and then reads 1.
